present_inv_player: RTL
=======================

// Module: present_inv_player
// PURPOSE
//  Inverse PRESENT bit-permutation layer (pLayer^-1) for the decryption datapath.
//  - Accepts one 64-bit state word over a valid/ready handshake.
//  - Permutes it iteratively, LANES bits per cycle, and presents the result on a second valid/ready handshake.
//  - Sits between the round-key XOR and the inverse S-box layer in the decrypt round loop.
// PARAMETERS
//  BLOCK_W  64  state width; only 64 is supported
//  LANES    8   output bits resolved per cycle; legal values 1,2,4,8,16,32,64
// PORTS
//  Clock      in   1        rising-edge clock
//  Reset_n    in   1        asynchronous active-low reset
//  in_valid   in   1        in_data is valid
//  in_ready   out  1        block can accept a word
//  in_data    in   BLOCK_W  state word to un-permute
//  out_valid  out  1        out_data holds a finished result
//  out_ready  in   1        downstream accepts out_data
//  out_data   out  BLOCK_W  inverse-permuted word
// BEHAVIOUR
//  - Mapping: out[i] = in[(16*i) mod 63] for i = 0..62; out[63] = in[63].
//    This is the exact inverse of the forward pLayer P(i) = 16*i mod 63.
//  - Reset (async assert, sync-safe release): state=IDLE, in_ready=1, out_valid=0, out_data=0.
//    The internal src register, work register and index counter are also cleared.
//  - FSM states:
//    - IDLE:
//      - in_ready=1.
//      - On in_valid&&in_ready: latch in_data into src, clear work, set idx=0, go to PERM.
//    - PERM:
//      - in_ready=0.
//      - Each cycle writes work[idx+k] = src[map(idx+k)] for k = 0..LANES-1, then idx += LANES.
//      - When idx+LANES == BLOCK_W, that cycle's write completes the word; copy the final value to out_data and go to DONE.
//    - DONE:
//      - out_valid=1; out_data stays stable until the transfer.
//      - On out_ready: out_valid=0 next cycle, go to IDLE.
//  - Latency: BLOCK_W/LANES cycles in PERM. out_valid rises on the edge ending the last PERM cycle.
//    With defaults, accept on edge N gives out_valid high after edge N+8.
//  - Throughput: one word per BLOCK_W/LANES+2 cycles; no overlap, in_ready is low through PERM and DONE.
//  - Index arithmetic:
//    - idx is $clog2(BLOCK_W) bits wide and never wraps past BLOCK_W-LANES.
//    - map() computes 16*i mod 63 on 10-bit intermediates; the i==63 case is special-cased and never fed to mod.
//  - Boundary conditions:
//    - in_valid while not IDLE: ignored; the source must hold the word per valid/ready rules.
//    - out_ready high before out_valid: no effect.
//    - out_ready held high: transfer happens on the first DONE cycle.
//    - Reset asserted mid-PERM or in DONE: the word is dropped; outputs return to reset values immediately.
//    - LANES == 64: PERM lasts exactly one cycle.
// STRUCTURE
//  - Shared package present_pkg holds:
//    - PRESENT_BLOCK_W = 64;
//    - typedef logic [63:0] present_state_t;
//    - enum {IDLE, PERM, DONE} pl_state_e;
//    - function inv_p_index(int i) returning the source bit for output bit i.
//    The forward pLayer uses the same package.
//  - No sub-module: FSM, counter and lane mux live in one module. The lane mux is a generate loop over k.
// TESTING
//  1. Reset mid-PERM: send 64'hFFFF_FFFF_FFFF_FFFF, pulse Reset_n low at the 3rd PERM cycle.
//     -> out_valid=0 and in_ready=1 immediately; the next word is processed cleanly.
//  2. Directed bits, one word each:
//     - 64'h0000_0000_0001_0000 -> 64'h0000_0000_0000_0002
//     - 64'h0000_0000_0000_0010 -> 64'h0000_0000_0001_0000
//     - 64'h4000_0000_0000_0000 -> 64'h0800_0000_0000_0000
//     - 64'h8000_0000_0000_0000 -> 64'h8000_0000_0000_0000
//  3. Latency and backpressure: accept at edge N with out_ready=0.
//     -> out_valid rises after edge N+8 and stays stable for 20 cycles.
//     -> Raising out_ready completes the transfer in 1 cycle; in_ready=1 the next cycle.
//  4. Handshake: hold in_valid high with a second word during PERM.
//     -> Not accepted until IDLE; both words come out in order and correct.
//  5. Round trip: 1000 random words through the forward pLayer and this block.
//     -> Output equals the original word. Repeat for LANES = 1, 8 and 64.

Source files
------------

// File: rtl/present_pkg.sv
// Shared PRESENT definitions: block width, state word type, permutation FSM states
// and the bit-index helpers used by both the forward and inverse pLayer.
package present_pkg;

    localparam int PRESENT_BLOCK_W = 64;

    typedef logic [63:0] present_state_t;

    typedef enum logic [1:0] {
        IDLE,
        PERM,
        DONE
    } pl_state_e;

    // Forward pLayer destination of input bit i: P(i) = 16*i mod 63, bit 63 fixed.
    function automatic logic [5:0] p_index(int i);
        logic [9:0] prod;
        if (i == 63) return 6'd63;
        prod = 10'(i) << 4;
        return 6'(prod % 10'd63);
    endfunction

    // Inverse pLayer: output bit i takes input bit 16*i mod 63, bit 63 fixed.
    function automatic logic [5:0] inv_p_index(int i);
        logic [9:0] prod;
        if (i == 63) return 6'd63;
        prod = 10'(i) << 4;
        return 6'(prod % 10'd63);
    endfunction

endpackage

// File: rtl/present_inv_player.sv
// Inverse PRESENT bit permutation, resolved LANES output bits per cycle between
// an input and an output valid/ready handshake.
module present_inv_player
    import present_pkg::*;
#(
    parameter int BLOCK_W = PRESENT_BLOCK_W,
    parameter int LANES   = 8
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data
);

    localparam int IDX_W = $clog2(BLOCK_W);
    localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(LANES);

    pl_state_e          state;
    pl_state_e          state_next;
    logic [BLOCK_W-1:0] src;
    logic [BLOCK_W-1:0] work;
    logic [BLOCK_W-1:0] work_next;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   lane_pos [LANES];
    logic [LANES-1:0]   lane_bits;
    logic               last_step;

    assign last_step = (int'(idx) + LANES == BLOCK_W);

    // Lane mux: each lane picks its source bit through the inverse mapping.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_pos[k]  = idx + IDX_W'(k);
        assign lane_bits[k] = src[inv_p_index(int'(lane_pos[k]))];
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        work_next = work;
        for (int k = 0; k < LANES; k++) begin
            work_next[lane_pos[k]] = lane_bits[k];
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = PERM;
            end
            PERM: begin
                if (last_step) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // The working registers are plain flops, so clearing them on reset is cheap and keeps
    // a dropped word from lingering after an abort.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            src      <= '0;
            work     <= '0;
            idx      <= '0;
            out_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        src  <= in_data;
                        work <= '0;
                        idx  <= '0;
                    end
                end
                PERM: begin
                    work <= work_next;
                    if (last_step) out_data <= work_next;
                    else           idx      <= idx + IDX_STEP;
                end
                default: ;
            endcase
        end
    end

endmodule
